// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and constants for the renaming register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int ROB_SIZE = 16;

  typedef logic [31:0]                 DATA_TYPE;
  typedef logic [4:0]                  REG_INDEX_TYPE;
  typedef logic [$clog2(ROB_SIZE)-1:0] ROB_INDEX_TYPE;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with per-register busy bit and
//               ROB rename tag. Combinational source lookups bypass the
//               current-cycle commit but not the current-cycle rename.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  // rename
  input  logic                 issue_ready,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_IDX_W-1:0] issue_rob_index,
  // commit write
  input  logic                 rob_to_reg_commit,
  input  logic [4:0]           rob_to_reg_index,
  input  logic [ROB_IDX_W-1:0] rob_to_reg_rob_index,
  input  logic [31:0]          rob_to_reg_val,
  // decoder lookups
  input  logic [4:0]           dc_rs1_index,
  input  logic [4:0]           dc_rs2_index,
  output logic                 reg_to_dc_rs1_busy,
  output logic [ROB_IDX_W-1:0] reg_to_dc_rs1_tag,
  output logic [31:0]          reg_to_dc_rs1_val,
  output logic                 reg_to_dc_rs2_busy,
  output logic [ROB_IDX_W-1:0] reg_to_dc_rs2_tag,
  output logic [31:0]          reg_to_dc_rs2_val
);

  localparam int LW = 1 + ROB_IDX_W + 32;

  DATA_TYPE               r_val  [REG_NUM];
  logic [REG_NUM-1:0]     r_busy;
  logic [ROB_IDX_W-1:0]   r_tag  [REG_NUM];

  logic [LW-1:0]          w_rs1;
  logic [LW-1:0]          w_rs2;
  logic                   w_commit_en;
  logic                   w_issue_en;

  // Packed {busy, tag, val} for one source, with x0 forced to zero and the
  // in-flight commit forwarded when it retires the producer this reg waits on.
  function automatic logic [LW-1:0] read_port(
    input REG_INDEX_TYPE        idx,
    input DATA_TYPE             val,
    input logic                 busy,
    input logic [ROB_IDX_W-1:0] tag,
    input logic                 cm,
    input REG_INDEX_TYPE        cidx,
    input logic [ROB_IDX_W-1:0] crob,
    input DATA_TYPE             cval
  );
    logic [LW-1:0] res;
    res = {busy, tag, val};
    if (idx == '0) begin
      res = '0;
    end else if (cm && (cidx == idx) && busy && (tag == crob)) begin
      res = {FALSE, tag, cval};
    end
    return res;
  endfunction

  assign w_commit_en = rob_to_reg_commit && (rob_to_reg_index != '0);
  assign w_issue_en  = issue_ready && (issue_rd != '0);

  assign w_rs1 = read_port(dc_rs1_index, r_val[dc_rs1_index], r_busy[dc_rs1_index],
                           r_tag[dc_rs1_index], rob_to_reg_commit, rob_to_reg_index,
                           rob_to_reg_rob_index, rob_to_reg_val);
  assign w_rs2 = read_port(dc_rs2_index, r_val[dc_rs2_index], r_busy[dc_rs2_index],
                           r_tag[dc_rs2_index], rob_to_reg_commit, rob_to_reg_index,
                           rob_to_reg_rob_index, rob_to_reg_val);

  assign {reg_to_dc_rs1_busy, reg_to_dc_rs1_tag, reg_to_dc_rs1_val} = w_rs1;
  assign {reg_to_dc_rs2_busy, reg_to_dc_rs2_tag, reg_to_dc_rs2_val} = w_rs2;

  // State update; later assignments override earlier ones, so flush beats the
  // commit's busy clear and a same-register rename beats the commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit_en) begin
        r_val[rob_to_reg_index] <= rob_to_reg_val;
        if (r_busy[rob_to_reg_index] && (r_tag[rob_to_reg_index] == rob_to_reg_rob_index)) begin
          r_busy[rob_to_reg_index] <= FALSE;
        end
      end
      if (clr_in) begin
        r_busy <= '0;
      end else if (w_issue_en) begin
        r_busy[issue_rd] <= TRUE;
        r_tag[issue_rd]  <= issue_rob_index;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file: array-based reference model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clr_in;
  logic          issue_ready;
  logic [4:0]    issue_rd;
  logic [RW-1:0] issue_rob_index;
  logic          rob_to_reg_commit;
  logic [4:0]    rob_to_reg_index;
  logic [RW-1:0] rob_to_reg_rob_index;
  logic [31:0]   rob_to_reg_val;
  logic [4:0]    dc_rs1_index, dc_rs2_index;
  logic          rs1_busy, rs2_busy;
  logic [RW-1:0] rs1_tag, rs2_tag;
  logic [31:0]   rs1_val, rs2_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  reg_file #(.REG_NUM(32), .ROB_IDX_W(RW)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .clr_in               (clr_in),
    .issue_ready          (issue_ready),
    .issue_rd             (issue_rd),
    .issue_rob_index      (issue_rob_index),
    .rob_to_reg_commit    (rob_to_reg_commit),
    .rob_to_reg_index     (rob_to_reg_index),
    .rob_to_reg_rob_index (rob_to_reg_rob_index),
    .rob_to_reg_val       (rob_to_reg_val),
    .dc_rs1_index         (dc_rs1_index),
    .dc_rs2_index         (dc_rs2_index),
    .reg_to_dc_rs1_busy   (rs1_busy),
    .reg_to_dc_rs1_tag    (rs1_tag),
    .reg_to_dc_rs1_val    (rs1_val),
    .reg_to_dc_rs2_busy   (rs2_busy),
    .reg_to_dc_rs2_tag    (rs2_tag),
    .reg_to_dc_rs2_val    (rs2_val)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];
  bit            m_valid = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
      m_valid = 1'b1;
    end else if (rdy_in) begin
      int c, r;
      c = int'(rob_to_reg_index);
      r = int'(issue_rd);
      if (rob_to_reg_commit && c != 0) begin
        m_val[c] = rob_to_reg_val;
        if (m_busy[c] && m_tag[c] == rob_to_reg_rob_index) m_busy[c] = 0;
      end
      if (clr_in) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (issue_ready && r != 0) begin
        m_busy[r] = 1;
        m_tag[r]  = issue_rob_index;
      end
    end
  end

  // Expected {busy, tag, val} seen by a lookup of register idx right now.
  function automatic logic [RW+32:0] expect_lookup(input logic [4:0] idx);
    int k;
    k = int'(idx);
    if (k == 0) return '0;
    if (rob_to_reg_commit && rob_to_reg_index == idx && m_busy[k] && m_tag[k] == rob_to_reg_rob_index)
      return {1'b0, m_tag[k], rob_to_reg_val};
    return {m_busy[k], m_tag[k], m_val[k]};
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (m_valid) begin
      logic [RW+32:0] e1, e2;
      e1 = expect_lookup(dc_rs1_index);
      e2 = expect_lookup(dc_rs2_index);
      chk("model rs1_busy", 32'(rs1_busy), 32'(e1[RW+32]));
      chk("model rs1_tag",  32'(rs1_tag),  32'(e1[RW+31:32]));
      chk("model rs1_val",  rs1_val,       e1[31:0]);
      chk("model rs2_busy", 32'(rs2_busy), 32'(e2[RW+32]));
      chk("model rs2_tag",  32'(rs2_tag),  32'(e2[RW+31:32]));
      chk("model rs2_val",  rs2_val,       e2[31:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk_in); #1;
  endtask

  task automatic mid();
    @(negedge clk_in); #1;
  endtask

  task automatic quiet();
    clr_in = 0; issue_ready = 0; rob_to_reg_commit = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] t);
    issue_ready = 1; issue_rd = rd; issue_rob_index = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [RW-1:0] t, input logic [31:0] v);
    rob_to_reg_commit = 1; rob_to_reg_index = rd; rob_to_reg_rob_index = t; rob_to_reg_val = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1; rdy_in = 1; quiet();
    issue_rd = 0; issue_rob_index = 0;
    rob_to_reg_index = 0; rob_to_reg_rob_index = 0; rob_to_reg_val = 0;
    dc_rs1_index = 5; dc_rs2_index = 6;
    cyc(); cyc();
    rst_in = 0;
    mid();
    chk("reset x5 busy", 32'(rs1_busy), 0);
    chk("reset x5 val",  rs1_val, 0);

    // rename x5 -> tag 3, not visible in the same cycle
    cyc(); issue(5, 3);
    mid(); chk("no issue bypass busy", 32'(rs1_busy), 0);
    cyc(); quiet();
    mid(); chk("x5 busy", 32'(rs1_busy), 1); chk("x5 tag", 32'(rs1_tag), 3);
    // commit with matching tag: bypass, then stored
    cyc(); commit(5, 3, 32'hDEAD);
    mid(); chk("bypass busy", 32'(rs1_busy), 0); chk("bypass val", rs1_val, 32'hDEAD);
    cyc(); quiet();
    mid(); chk("after commit busy", 32'(rs1_busy), 0); chk("after commit val", rs1_val, 32'hDEAD);

    // stale commit: value written, busy/tag preserved
    cyc(); issue(5, 7);
    cyc(); quiet(); commit(5, 3, 32'h11);
    mid(); chk("stale no bypass val", rs1_val, 32'hDEAD); chk("stale busy", 32'(rs1_busy), 1);
    cyc(); quiet();
    mid(); chk("stale val", rs1_val, 32'h11); chk("stale busy kept", 32'(rs1_busy), 1);
    chk("stale tag kept", 32'(rs1_tag), 7);

    // issue and matching commit to x6 in one cycle: issue wins
    cyc(); issue(6, 2);
    cyc(); quiet(); issue(6, 9); commit(6, 2, 32'h22);
    mid(); chk("same-cycle bypass busy", 32'(rs2_busy), 0); chk("same-cycle bypass val", rs2_val, 32'h22);
    cyc(); quiet();
    mid(); chk("x6 busy", 32'(rs2_busy), 1); chk("x6 tag", 32'(rs2_tag), 9); chk("x6 val", rs2_val, 32'h22);

    // x1..x4 busy, then flush with commit x2 and issue x8
    for (int i = 1; i <= 4; i++) begin
      cyc(); issue(5'(i), 4'(i));
    end
    cyc(); quiet(); clr_in = 1; commit(2, 5, 32'h33); issue(8, 6);
    cyc(); quiet(); dc_rs1_index = 1; dc_rs2_index = 2;
    mid(); chk("flush x1 busy", 32'(rs1_busy), 0); chk("flush x2 busy", 32'(rs2_busy), 0);
    chk("flush x2 val", rs2_val, 32'h33);
    cyc(); dc_rs1_index = 8; dc_rs2_index = 4;
    mid(); chk("flush x8 busy", 32'(rs1_busy), 0); chk("flush x4 busy", 32'(rs2_busy), 0);

    // x0 ignores writes and renames
    cyc(); issue(0, 1); commit(0, 0, 32'h44); dc_rs1_index = 0; dc_rs2_index = 7;
    cyc(); quiet();
    mid(); chk("x0 val", rs1_val, 0); chk("x0 busy", 32'(rs1_busy), 0); chk("x0 tag", 32'(rs1_tag), 0);
    // stalled cycle: nothing changes
    cyc(); rdy_in = 0; issue(7, 5); commit(7, 0, 32'h55);
    cyc(); rdy_in = 1; quiet();
    mid(); chk("stall x7 busy", 32'(rs2_busy), 0); chk("stall x7 val", rs2_val, 0);

    // reset mid-rename discards issue and commit
    cyc(); issue(9, 4); commit(5, 7, 32'h66); rst_in = 1; dc_rs1_index = 9; dc_rs2_index = 5;
    cyc(); rst_in = 0; quiet();
    mid(); chk("rst x9 busy", 32'(rs1_busy), 0); chk("rst x5 val", rs2_val, 0);
    chk("rst x5 busy", 32'(rs2_busy), 0);

    // short pseudo-random sweep against the model on a few registers
    for (int n = 0; n < 150; n++) begin
      cyc();
      rdy_in = ($urandom_range(0, 7) != 0);
      clr_in = ($urandom_range(0, 15) == 0);
      issue_ready = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 5));
      issue_rob_index = 4'($urandom_range(0, 3));
      rob_to_reg_commit = $urandom_range(0, 1);
      rob_to_reg_index = 5'($urandom_range(0, 5));
      rob_to_reg_rob_index = 4'($urandom_range(0, 3));
      rob_to_reg_val = $urandom;
      dc_rs1_index = 5'($urandom_range(0, 5));
      dc_rs2_index = 5'($urandom_range(0, 5));
    end
    cyc(); quiet(); rdy_in = 1;
    mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
